// File: rtl/l1_cache_pkg.sv
// Shared constants, miss-engine state encoding and address-field helpers for the L1 data cache.
package l1_cache_pkg;

    localparam int ADDR_SIZE      = 14;
    localparam int WORD_SIZE      = 32;
    localparam int WORDS_PER_LINE = 8;
    localparam int LINES_PER_SET  = 32;
    localparam int CPU_ADDR_BITS  = 32;

    localparam int OFFSET_BITS = $clog2(WORDS_PER_LINE);
    localparam int INDEX_BITS  = $clog2(LINES_PER_SET);
    localparam int TAG_BITS    = ADDR_SIZE - INDEX_BITS - OFFSET_BITS;

    typedef logic [CPU_ADDR_BITS-1:0] addr_t;
    typedef logic [TAG_BITS-1:0]      tag_t;
    typedef logic [INDEX_BITS-1:0]    index_t;
    typedef logic [OFFSET_BITS-1:0]   offset_t;
    typedef logic [WORD_SIZE-1:0]     word_t;

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} miss_state_t;

    function automatic tag_t addr_tag(input addr_t a);
        return a[OFFSET_BITS+INDEX_BITS +: TAG_BITS];
    endfunction

    function automatic index_t addr_index(input addr_t a);
        return a[OFFSET_BITS +: INDEX_BITS];
    endfunction

    function automatic offset_t addr_offset(input addr_t a);
        return a[OFFSET_BITS-1:0];
    endfunction

    // Bits above the cache address space are carried over from base unchanged.
    function automatic addr_t line_word_addr(input addr_t base, input tag_t tag,
                                             input index_t index, input offset_t offset);
        addr_t r;
        r = base;
        r[ADDR_SIZE-1:0] = {tag, index, offset};
        return r;
    endfunction

endpackage

// File: rtl/l1_miss_handler.sv
// Miss/refill engine between the CPU port and the 2-way L1 data cache: dirty write-back, word-wise refill.
// Optional build macro CRITICAL_WORD_FIRST_EN starts the refill at the missed word offset.
module l1_miss_handler
    import l1_cache_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_rd,
    input  logic                     cpu_we,
    input  logic [CPU_ADDR_BITS-1:0] cpu_addr,
    output logic                     stall,
    input  logic                     cache_hit,
    input  logic                     cache_dirty,
    input  logic [TAG_BITS-1:0]      victim_tag,
    input  logic [WORD_SIZE-1:0]     cache_dout,
    output logic [CPU_ADDR_BITS-1:0] cache_addr,
    output logic                     cache_we_cache,
    output logic [WORD_SIZE-1:0]     cache_wdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [CPU_ADDR_BITS-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]     mem_wdata,
    input  logic [WORD_SIZE-1:0]     mem_rdata,
    input  logic                     mem_ack
);

    miss_state_t state_q, state_d;
    offset_t     cnt_q, cnt_d;
    offset_t     start_q, start_d;
    logic [CPU_ADDR_BITS-OFFSET_BITS-1:0] line_q, line_d;
    logic        we_cache_q, we_cache_d;
    addr_t       fill_addr_q, fill_addr_d;
    word_t       fill_data_q, fill_data_d;

    offset_t     miss_start;
    addr_t       line_base;

`ifdef CRITICAL_WORD_FIRST_EN
    assign miss_start = addr_offset(cpu_addr);
`else
    assign miss_start = '0;
`endif

    assign line_base      = {line_q, {OFFSET_BITS{1'b0}}};
    assign cache_we_cache = we_cache_q;
    assign cache_wdata    = fill_data_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        start_d     = start_q;
        line_d      = line_q;
        we_cache_d  = 1'b0;
        fill_addr_d = fill_addr_q;
        fill_data_d = fill_data_q;
        stall       = 1'b0;
        cache_addr  = cpu_addr;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        unique case (state_q)
            IDLE: begin
                if ((cpu_rd || cpu_we) && !cache_hit) begin
                    stall   = 1'b1;
                    line_d  = cpu_addr[CPU_ADDR_BITS-1:OFFSET_BITS];
                    start_d = miss_start;
                    cnt_d   = cache_dirty ? '0 : miss_start;
                    state_d = cache_dirty ? WB : FILL;
                end
            end
            WB: begin
                stall      = 1'b1;
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = line_word_addr(line_base, victim_tag, addr_index(line_base), cnt_q);
                mem_wdata  = cache_dout;
                cache_addr = mem_addr;
                if (mem_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == offset_t'(WORDS_PER_LINE - 1)) begin
                        cnt_d   = start_q;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                stall      = 1'b1;
                mem_addr   = line_word_addr(line_base, addr_tag(line_base), addr_index(line_base), cnt_q);
                cache_addr = mem_addr;
                if (we_cache_q) begin
                    // Strobe cycle: the counter has already advanced, so returning to start means all words landed.
                    cache_addr = fill_addr_q;
                    if (cnt_q == start_q) begin
                        state_d = DONE;
                    end
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        we_cache_d  = 1'b1;
                        fill_addr_d = mem_addr;
                        fill_data_d = mem_rdata;
                        cnt_d       = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                stall   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            start_q     <= '0;
            line_q      <= '0;
            we_cache_q  <= 1'b0;
            fill_addr_q <= '0;
            fill_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            line_q      <= line_d;
            we_cache_q  <= we_cache_d;
            fill_addr_q <= fill_addr_d;
            fill_data_q <= fill_data_d;
        end
    end

endmodule

// File: tb/tb_l1_miss_handler.sv
// Self-checking bench for l1_miss_handler: vector table plus scoreboard queues for memory and refill traffic.
module tb_l1_miss_handler;
    import l1_cache_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     cpu_rd, cpu_we;
    logic [CPU_ADDR_BITS-1:0] cpu_addr;
    logic                     stall;
    logic                     cache_hit, cache_dirty;
    logic [TAG_BITS-1:0]      victim_tag;
    logic [WORD_SIZE-1:0]     cache_dout;
    logic [CPU_ADDR_BITS-1:0] cache_addr;
    logic                     cache_we_cache;
    logic [WORD_SIZE-1:0]     cache_wdata;
    logic                     mem_req, mem_we;
    logic [CPU_ADDR_BITS-1:0] mem_addr;
    logic [WORD_SIZE-1:0]     mem_wdata, mem_rdata;
    logic                     mem_ack;

    int  ack_wait;
    int  wait_cnt;
    logic spur;
    logic mon_en;
    int  pulse_cnt;
    int  n_vec;
    int  n_err;

    typedef struct {
        logic        we;
        addr_t       addr;
        word_t       data;
    } mem_txn_t;

    typedef struct {
        addr_t       addr;
        word_t       data;
    } fill_txn_t;

    typedef struct {
        logic        rd;
        logic        we;
        addr_t       addr;
        logic        hit;
        logic        dirty;
        tag_t        vtag;
        int          wait_c;
        logic        spur;
        int          exp_lat;
    } vec_t;

    mem_txn_t  mem_q[$];
    fill_txn_t fill_q[$];
    vec_t      vecs[8];

    always #5 clk = ~clk;

    l1_miss_handler dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_rd         (cpu_rd),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .stall          (stall),
        .cache_hit      (cache_hit),
        .cache_dirty    (cache_dirty),
        .victim_tag     (victim_tag),
        .cache_dout     (cache_dout),
        .cache_addr     (cache_addr),
        .cache_we_cache (cache_we_cache),
        .cache_wdata    (cache_wdata),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack)
    );

    // Cache and memory data models: contents are a fixed tag plus the low address bits.
    assign cache_dout = {16'hCAC4, cache_addr[15:0]};
    assign mem_rdata  = {16'hD47A, mem_addr[15:0]};
    assign mem_ack    = (mem_req && (wait_cnt >= ack_wait)) || spur;

    always @(posedge clk) wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_expect(input vec_t v);
        addr_t     wb_base, fill_base, a;
        int        start;
        mem_txn_t  m;
        fill_txn_t f;
        wb_base   = (v.addr & ~32'h0000_3FFF) | (32'(v.vtag) << 8) | (v.addr & 32'h0000_00F8);
        fill_base = v.addr & ~32'h0000_0007;
`ifdef CRITICAL_WORD_FIRST_EN
        start = int'(v.addr[2:0]);
`else
        start = 0;
`endif
        if (v.dirty) begin
            for (int i = 0; i < 8; i++) begin
                a = wb_base | 32'(i);
                m.we = 1'b1; m.addr = a; m.data = {16'hCAC4, a[15:0]};
                mem_q.push_back(m);
            end
        end
        for (int i = 0; i < 8; i++) begin
            a = fill_base | 32'((start + i) % 8);
            m.we = 1'b0; m.addr = a; m.data = {16'hD47A, a[15:0]};
            mem_q.push_back(m);
            f.addr = a; f.data = {16'hD47A, a[15:0]};
            fill_q.push_back(f);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic     prev_pending;
        addr_t    prev_addr;
        logic     prev_we;
        mem_txn_t m;
        fill_txn_t f;
        prev_pending = 1'b0;
        prev_addr    = '0;
        prev_we      = 1'b0;
        forever begin
            @(negedge clk);
            if (cache_we_cache) pulse_cnt++;
            if (mon_en) begin
                if (prev_pending) begin
                    check("req_held", {31'd0, mem_req}, 32'd1);
                    check("addr_held", mem_addr, prev_addr);
                    check("we_held", {31'd0, mem_we}, {31'd0, prev_we});
                end
                if (mem_req && mem_ack) begin
                    if (mem_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL extra_mem_txn: got addr 0x%08h we %0b, expected none", mem_addr, mem_we);
                    end else begin
                        m = mem_q.pop_front();
                        check("mem_we", {31'd0, mem_we}, {31'd0, m.we});
                        check("mem_addr", mem_addr, m.addr);
                        if (m.we) check("mem_wdata", mem_wdata, m.data);
                    end
                end
                if (cache_we_cache) begin
                    check("req_low_in_pulse", {31'd0, mem_req}, 32'd0);
                    if (fill_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL extra_we_cache: got addr 0x%08h, expected no strobe", cache_addr);
                    end else begin
                        f = fill_q.pop_front();
                        check("fill_addr", cache_addr, f.addr);
                        check("fill_data", cache_wdata, f.data);
                    end
                end
                prev_pending = mem_req && !mem_ack;
                prev_addr    = mem_addr;
                prev_we      = mem_we;
            end else begin
                prev_pending = 1'b0;
            end
        end
    end

    task automatic apply_vec(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        ack_wait    = v.wait_c;
        spur        = v.spur;
        cache_hit   = v.hit;
        cache_dirty = v.dirty;
        victim_tag  = v.vtag;
        cpu_addr    = v.addr;
        cpu_rd      = v.rd;
        cpu_we      = v.we;
        if (!v.hit) push_expect(v);
        #1;
        check({tag, "_stall_at_req"}, {31'd0, stall}, {31'd0, !v.hit});
        @(posedge clk);
        lat = 0;
        forever begin
            #1;
            if (!v.hit && fill_q.size() == 0) cache_hit = 1'b1;
            if (!stall) break;
            lat++;
            if (lat > 200) break;
            @(posedge clk);
        end
        check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, "_mem_q_drained"}, 32'(mem_q.size()), 32'd0);
        check({tag, "_fill_q_drained"}, 32'(fill_q.size()), 32'd0);
        if (v.hit) check({tag, "_no_mem_req"}, {31'd0, mem_req}, 32'd0);
        mem_q.delete();
        fill_q.delete();
        @(negedge clk);
        cpu_rd = 1'b0;
        cpu_we = 1'b0;
        spur   = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int base;
        n_vec = 0; n_err = 0; pulse_cnt = 0;
        reset = 1'b1; mon_en = 1'b0; spur = 1'b0; ack_wait = 0;
        cpu_rd = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
        cache_hit = 1'b0; cache_dirty = 1'b0; victim_tag = '0;

        // Dirty-miss vector: victim tag 0x14 at index 4 places the write-back at 0x1420..0x1427.
        vecs[0] = '{rd:1'b1, we:1'b0, addr:32'h0000_0040, hit:1'b1, dirty:1'b0, vtag:6'h00, wait_c:0, spur:1'b1, exp_lat:0};
        vecs[1] = '{rd:1'b1, we:1'b0, addr:32'h0000_0123, hit:1'b0, dirty:1'b0, vtag:6'h00, wait_c:0, spur:1'b0, exp_lat:17};
        vecs[2] = '{rd:1'b0, we:1'b1, addr:32'h0000_0021, hit:1'b0, dirty:1'b1, vtag:6'h14, wait_c:0, spur:1'b0, exp_lat:25};
        vecs[3] = '{rd:1'b1, we:1'b1, addr:32'h0000_3FFD, hit:1'b0, dirty:1'b0, vtag:6'h00, wait_c:0, spur:1'b0, exp_lat:17};
        vecs[4] = '{rd:1'b0, we:1'b1, addr:32'h0000_0040, hit:1'b1, dirty:1'b1, vtag:6'h3F, wait_c:0, spur:1'b0, exp_lat:0};
        vecs[5] = '{rd:1'b1, we:1'b0, addr:32'h00AB_C0D7, hit:1'b0, dirty:1'b1, vtag:6'h2A, wait_c:0, spur:1'b1, exp_lat:25};
        vecs[6] = '{rd:1'b1, we:1'b0, addr:32'h0000_0125, hit:1'b0, dirty:1'b0, vtag:6'h00, wait_c:3, spur:1'b0, exp_lat:41};
        vecs[7] = '{rd:1'b1, we:1'b0, addr:32'h0000_0125, hit:1'b0, dirty:1'b0, vtag:6'h00, wait_c:0, spur:1'b0, exp_lat:17};

        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_we_cache", {31'd0, cache_we_cache}, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 8; i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted during the fourth refill word abandons the burst.
        @(negedge clk);
        mon_en = 1'b0;
        base = pulse_cnt;
        cache_hit = 1'b0; cache_dirty = 1'b0; ack_wait = 0; spur = 1'b0;
        cpu_addr = 32'h0000_0123; cpu_rd = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            #1;
            if (pulse_cnt - base >= 3) break;
        end
        check("rst_burst_pulses_before", 32'(pulse_cnt - base), 32'd3);
        @(negedge clk);
        cpu_rd = 1'b0;
        reset  = 1'b1;
        #1;
        check("rst_burst_stall", {31'd0, stall}, 32'd0);
        check("rst_burst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_burst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_burst_we_cache", {31'd0, cache_we_cache}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("rst_burst_pulses_after", 32'(pulse_cnt - base), 32'd3);
        check("rst_burst_idle_req", {31'd0, mem_req}, 32'd0);
        check("rst_burst_idle_stall", {31'd0, stall}, 32'd0);
        mon_en = 1'b1;

        apply_vec(vecs[1], "after_reset");
        apply_vec(vecs[2], "after_reset_dirty");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
